// File: rtl/i4003_loader_if.sv
// Load handshake between a requester and the i4003 chain loader: valid/ready word transfer plus abort.
interface i4003_loader_if #(
  parameter int TOTAL = 10
);
  logic             load_valid;
  logic             load_ready;
  logic [TOTAL-1:0] load_data;
  logic             abort;

  modport master (
    output load_valid,
    output load_data,
    output abort,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  abort,
    output load_ready
  );
endinterface

// File: rtl/i4003_loader.sv
// Loads a cascaded i4003 chain MSB-first from a parallel word, generating cp and gating enable.
// Optional feature macro I4003_LOADER_READBACK_EN captures the previous chain contents from serial_out.
module i4003_loader #(
  parameter int SR_BITS = 10,
  parameter int NUM_SR  = 1,
  parameter int CP_DIV  = 4
) (
  input  logic                      sysclk,
  input  logic                      poc_n,
  i4003_loader_if.slave             load,
  output logic                      cp,
  output logic                      serial_in,
  output logic                      enable,
  input  logic                      serial_out,
  output logic                      busy,
  output logic                      done,
  output logic [SR_BITS*NUM_SR-1:0] readback,
  output logic                      readback_valid
);
  localparam int TOTAL = SR_BITS * NUM_SR;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int PW    = (CP_DIV > 1) ? $clog2(CP_DIV) : 1;

  localparam logic [PW-1:0] PHASE_LAST = PW'(CP_DIV - 1);
  localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(TOTAL);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_TAIL     = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [PW-1:0]    phase_r, phase_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [TOTAL-1:0] sreg_r, sreg_s;
  logic             cp_r, cp_s;
  logic             sin_r, sin_s;
  logic             enable_r, enable_s;
  logic             done_r, done_s;
  logic [TOTAL-1:0] rb_r, rb_s;
  logic             rbv_r, rbv_s;
  logic             phase_last_s;
  logic             xfer_s;
  logic             cancel_s;
  logic             bit_end_s;

  // Next state, counters and next values of the registered outputs.
  always_comb begin
    state_s      = state_r;
    phase_s      = phase_r;
    cnt_s        = cnt_r;
    sreg_s       = sreg_r;
    sin_s        = sin_r;
    enable_s     = enable_r;
    done_s       = 1'b0;
    xfer_s       = 1'b0;
    phase_last_s = (phase_r == PHASE_LAST);
    cancel_s     = load.abort && (state_r != ST_IDLE);
    bit_end_s    = (state_r == ST_SHIFT_HI) && phase_last_s;

    if (cancel_s) begin
      // Chain contents are now undefined, so enable stays low until a full load completes.
      state_s  = ST_IDLE;
      phase_s  = '0;
      cnt_s    = '0;
      sin_s    = 1'b0;
      enable_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load.load_valid && !load.abort) begin
            xfer_s   = 1'b1;
            state_s  = ST_SHIFT_LO;
            phase_s  = '0;
            cnt_s    = '0;
            sreg_s   = load.load_data;
            sin_s    = load.load_data[TOTAL-1];
            enable_s = 1'b0;
          end else begin
            phase_s = '0;
          end
        end
        ST_SHIFT_LO: begin
          if (phase_last_s) begin
            state_s = ST_SHIFT_HI;
            phase_s = '0;
          end else begin
            phase_s = phase_r + PHASE_ONE;
          end
        end
        ST_SHIFT_HI: begin
          if (phase_last_s) begin
            phase_s = '0;
            sreg_s  = sreg_r << 1'b1;
            cnt_s   = cnt_r + CNT_ONE;
            if (cnt_s == CNT_FULL) begin
              state_s = ST_TAIL;
            end else begin
              state_s = ST_SHIFT_LO;
              sin_s   = sreg_s[TOTAL-1];
            end
          end else begin
            phase_s = phase_r + PHASE_ONE;
          end
        end
        ST_TAIL: begin
          if (phase_last_s) begin
            state_s  = ST_IDLE;
            phase_s  = '0;
            enable_s = 1'b1;
            done_s   = 1'b1;
          end else begin
            phase_s = phase_r + PHASE_ONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          phase_s = '0;
        end
      endcase
    end

    cp_s = (state_s == ST_SHIFT_HI);
  end

  // Readback capture: each bit leaves the chain as cp falls, first-out bit lands at TOTAL-1.
  always_comb begin
`ifdef I4003_LOADER_READBACK_EN
    rbv_s = done_s;
    if (xfer_s) begin
      rb_s = '0;
    end else if (bit_end_s && !cancel_s) begin
      rb_s = (rb_r << 1'b1) | TOTAL'(serial_out);
    end else begin
      rb_s = rb_r;
    end
`else
    rb_s  = '0;
    rbv_s = 1'b0;
`endif
  end

`ifndef I4003_LOADER_READBACK_EN
  logic unused_serial_out;
  assign unused_serial_out = serial_out;
`endif

  // State, datapath and output registers.
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      state_r  <= ST_IDLE;
      phase_r  <= '0;
      cnt_r    <= '0;
      sreg_r   <= '0;
      cp_r     <= 1'b0;
      sin_r    <= 1'b0;
      enable_r <= 1'b0;
      done_r   <= 1'b0;
      rb_r     <= '0;
      rbv_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      phase_r  <= phase_s;
      cnt_r    <= cnt_s;
      sreg_r   <= sreg_s;
      cp_r     <= cp_s;
      sin_r    <= sin_s;
      enable_r <= enable_s;
      done_r   <= done_s;
      rb_r     <= rb_s;
      rbv_r    <= rbv_s;
    end
  end

  assign load.load_ready = (state_r == ST_IDLE);
  assign busy            = (state_r != ST_IDLE);
  assign cp              = cp_r;
  assign serial_in       = sin_r;
  assign enable          = enable_r;
  assign done            = done_r;
  assign readback        = rb_r;
  assign readback_valid  = rbv_r;
endmodule

// File: doc/i4003_loader.md
# i4003_loader

Sequencer that loads a cascaded chain of i4003 shift registers from a parallel word. It accepts a word through a valid/ready handshake and shifts it out MSB-first on `serial_in`, generating the `cp` shift clock. It holds the 4003 `enable` low while shifting and restores it when the chain is consistent. It sits between system-level output logic and the i4003 instances in the MCS-4 top level, replacing the free-running `clk2`/`data_pad[0]` hookup.

## Interface
- `SR_BITS`, 10: bits per i4003 device.
- `NUM_SR`, 1: cascaded devices; `TOTAL = SR_BITS*NUM_SR`.
- `CP_DIV`, 4: sysclk cycles per `cp` half-period; legal range ≥1.
- `sysclk`  in  1  system clock; all logic is on its rising edge.
- `poc_n`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  requester has a word.
- `load_ready`  out  1  loader idle and able to accept.
- `load_data`  in  TOTAL  word; bit TOTAL-1 shifted first.
- `abort`  in  1  synchronous cancel of an in-progress load.
- `cp`  out  1  shift clock to the i4003 `cp`.
- `serial_in`  out  1  serial data to the first i4003.
- `enable`  out  1  i4003 output enable, active high.
- `serial_out`  in  1  serial output of the last i4003 in the chain.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse on completion.
- `readback`  out  TOTAL  previous chain contents (see Configuration).
- `readback_valid`  out  1  one-cycle pulse with `done`.

## Operation
- States: IDLE, SHIFT_LO, SHIFT_HI, TAIL.
- Handshake: transfer occurs on a cycle with `load_valid && load_ready && !abort`. `load_data` is captured into an internal shift register on that cycle; later changes to `load_data` are ignored.
- `load_ready` = (state == IDLE). `busy` = !`load_ready`.
- IDLE → SHIFT_LO on transfer. `enable` drops to 0 on the next cycle.
- SHIFT_LO:
  - `cp` = 0, `serial_in` = current MSB of the shift register.
  - Lasts CP_DIV cycles, then → SHIFT_HI.
- SHIFT_HI:
  - `cp` = 1, `serial_in` unchanged.
  - Lasts CP_DIV cycles.
  - Then the shift register shifts left by 1 and the bit counter increments.
  - If the counter reaches TOTAL → TAIL, else → SHIFT_LO.
- TAIL: `cp` = 0 for CP_DIV cycles, then → IDLE. On the entry cycle into IDLE, `enable` = 1, `done` = 1, and `load_ready` = 1.
- Bit counter width is clog2(TOTAL+1). The phase counter counts 0..CP_DIV-1 and wraps.
- Abort while busy: next cycle state = IDLE, `cp` = 0, `serial_in` = 0, `enable` stays 0, no `done`, no `readback_valid`. Abort in IDLE has no effect other than blocking acceptance that cycle.
- After abort, `enable` stays 0 until the next load completes, because the chain contents are undefined.
- Back-to-back: a new word may be accepted on the same cycle `done` is asserted.

## Timing
- Reset values:
  - state IDLE
  - `cp` = 0, `serial_in` = 0, `enable` = 0
  - `load_ready` = 1, `busy` = 0, `done` = 0
  - `readback` = 0, `readback_valid` = 0
- Accept at cycle 0:
  - first `cp` rise at cycle CP_DIV+1
  - `done` at cycle 2·CP_DIV·TOTAL + CP_DIV + 1 (85 for the defaults)
- `serial_in` changes only on the cycle `cp` falls (SHIFT_HI→SHIFT_LO), which gives CP_DIV cycles of setup and hold around each rising edge.
- All outputs are registered. There are no combinational paths from inputs to outputs, except `load_ready`, which is a registered state decode.
- Reset asserted mid-load: all outputs go to their reset values immediately (asynchronously).

## Configuration
- `I4003_LOADER_READBACK_EN` defined:
  - `serial_out` is sampled on the sysclk cycle `cp` goes 1→0 and shifted into `readback` LSB-first-in, i.e. left shift with `serial_out` into bit 0.
  - At `done`, `readback` holds the chain contents prior to the load, first-out bit at TOTAL-1.
  - `readback_valid` pulses with `done`.
  - `readback` is cleared on accept.
- Not defined: `readback` = 0 and `readback_valid` = 0 constantly, and `serial_out` is unused (ports kept).

## Test plan
- Reset, then idle 10 cycles → `enable` = 0, `cp` = 0, `load_ready` = 1, `done` = 0.
- Load 10'h2A5 (defaults) → 10 `cp` rises; `serial_in` sampled at each rise = 1,0,1,0,1,0,0,1,0,1; `done` exactly 85 cycles after accept; `enable` 1 from that cycle.
- Assert `abort` at cycle 30 of a load → IDLE next cycle, `cp` = 0, `enable` = 0, no `done`. The next load of 10'h3FF completes normally with `enable` = 1.
- Hold `load_valid` continuously with words 10'h001 then 10'h200 → the second word is accepted on the `done` cycle of the first; 20 `cp` rises total; no gap cycles.
- `CP_DIV` = 1, `NUM_SR` = 2 → `cp` toggles every cycle, 20 rises, `done` at cycle 42.
- With `I4003_LOADER_READBACK_EN` and `serial_out` looped from a behavioural 10-bit chain: load 10'h155, then 10'h0F0 → second `readback` = 10'h155 with `readback_valid` on `done`.
